// File: rtl/counter_ctrl_if.sv
// Command handshake bundle between the register/control layer (master) and counter_ctrl (slave).
interface counter_ctrl_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_MODE;
    logic [3:0] CMD_START;
    logic [3:0] CMD_LIMIT;

    modport master (
        output CMD_VALID,
        output CMD_MODE,
        output CMD_START,
        output CMD_LIMIT,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_MODE,
        input  CMD_START,
        input  CMD_LIMIT,
        output CMD_READY
    );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for a 4-bit up/down loadable counter: one-shot down/up, periodic reload, ping-pong.
// Optional feature macro: PINGPONG_EN (mode 3 supported only when defined).
module counter_ctrl #(
    parameter int unsigned EVW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    counter_ctrl_if.slave   cmd,
    input  logic            ABORT,
    input  logic            TICK,
    output logic            BUSY,
    output logic            DONE,
    output logic            EVENT,
    output logic            ERR,
    output logic [EVW-1:0]  STATUS_EVENTS,
    output logic            CNT_CLEAR,
    output logic            CNT_LOAD,
    output logic            CNT_ENABLE,
    output logic            CNT_DOWN,
    output logic [3:0]      CNT_D,
    input  logic [3:0]      CNT_Q
);

    localparam logic [1:0] M_ONESHOT_DN = 2'd0;
    localparam logic [1:0] M_ONESHOT_UP = 2'd1;
    localparam logic [1:0] M_PERIODIC   = 2'd2;
    localparam logic [1:0] M_PINGPONG   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] mode_r;
    logic [3:0] start_r;
    logic [3:0] target_r;
    logic       dir_r;
`ifdef PINGPONG_EN
    logic [3:0] limit_r;
`endif

    logic           term;
    logic           mode_ok;
    logic [EVW-1:0] events_inc;

    assign term = (state == S_RUN) && (CNT_Q == target_r);

`ifdef PINGPONG_EN
    assign mode_ok = 1'b1;
`else
    assign mode_ok = (cmd.CMD_MODE != M_PINGPONG);
`endif

    assign events_inc = (STATUS_EVENTS == {EVW{1'b1}}) ? STATUS_EVENTS
                                                       : STATUS_EVENTS + EVW'(1);

    // Handshake and counter controls are decoded straight from state and inputs.
    assign cmd.CMD_READY = (state == S_IDLE) && !RST;
    assign BUSY          = (state != S_IDLE);
    assign CNT_CLEAR     = RST || ((state == S_RUN) && ABORT);
    assign CNT_LOAD      = (state == S_LOAD);
    assign CNT_ENABLE    = (state == S_RUN) && !ABORT && !term && TICK;
    assign CNT_DOWN      = dir_r;
    assign CNT_D         = start_r;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            mode_r        <= 2'd0;
            start_r       <= 4'd0;
            target_r      <= 4'd0;
            dir_r         <= 1'b0;
            DONE          <= 1'b0;
            EVENT         <= 1'b0;
            ERR           <= 1'b0;
            STATUS_EVENTS <= '0;
`ifdef PINGPONG_EN
            limit_r       <= 4'd0;
`endif
        end else begin
            DONE  <= 1'b0;
            EVENT <= 1'b0;
            ERR   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.CMD_VALID) begin
                        if (mode_ok) begin
                            mode_r        <= cmd.CMD_MODE;
                            start_r       <= cmd.CMD_START;
                            target_r      <= cmd.CMD_LIMIT;
                            dir_r         <= ~cmd.CMD_MODE[0];
                            STATUS_EVENTS <= '0;
`ifdef PINGPONG_EN
                            limit_r       <= cmd.CMD_LIMIT;
`endif
                            state         <= S_LOAD;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                    end else if (term) begin
                        case (mode_r)
                            M_ONESHOT_DN, M_ONESHOT_UP: begin
                                DONE  <= 1'b1;
                                state <= S_IDLE;
                            end
                            M_PERIODIC: begin
                                EVENT         <= 1'b1;
                                STATUS_EVENTS <= events_inc;
                                state         <= S_LOAD;
                            end
`ifdef PINGPONG_EN
                            M_PINGPONG: begin
                                // Bounce between the two endpoints without reloading.
                                EVENT         <= 1'b1;
                                STATUS_EVENTS <= events_inc;
                                dir_r         <= ~dir_r;
                                target_r      <= (target_r == limit_r) ? start_r : limit_r;
                            end
`endif
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer for the 4-bit up/down loadable counter. Accepts one command at a time over a valid/ready port. Drives the counter's CLEAR/LOAD/ENABLE/DOWN/D inputs and watches its Q output. Runs one of four timing modes: one-shot down, one-shot up, periodic reload, and ping-pong. Sits between the register/control layer and the counter instance, and turns external TICK strobes into counter steps.

## Interface
Parameters:
- EVW, 8, width of event counter STATUS_EVENTS

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-high
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  controller can accept a command
- CMD_MODE  in  2  0=ONESHOT_DN, 1=ONESHOT_UP, 2=PERIODIC, 3=PINGPONG
- CMD_START  in  4  value loaded into the counter
- CMD_LIMIT  in  4  terminal value
- ABORT  in  1  stop the current run
- TICK  in  1  count strobe, one step per high cycle in RUN
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse, one-shot finished
- EVENT  out  1  one-cycle pulse, terminal reached (PERIODIC/PINGPONG)
- ERR  out  1  one-cycle pulse, unsupported mode rejected
- STATUS_EVENTS  out  EVW  EVENT count since last accepted command, saturating
- CNT_CLEAR, CNT_LOAD, CNT_ENABLE, CNT_DOWN  out  1  counter controls
- CNT_D  out  4  counter load data
- CNT_Q  in  4  counter value

## Operation
- Registers: state, mode_r, start_r, limit_r, target_r (4), dir_r, DONE/EVENT/ERR, STATUS_EVENTS.
- Counter outputs are combinational from state and inputs.
- CNT_D = start_r at all times.
- CNT_DOWN = dir_r.
- term = (state==RUN) & (CNT_Q==target_r).
- IDLE: CMD_READY=1. On CMD_VALID:
  - capture mode, start, limit; clear STATUS_EVENTS.
  - target_r=limit; dir_r=1 for modes 0/2, 0 for modes 1/3.
  - Next state LOAD. An unsupported mode pulses ERR instead and stays in IDLE.
- LOAD (exactly one cycle): CNT_LOAD=1, then go to RUN.
- RUN:
  - ABORT has priority: CNT_CLEAR=1, CNT_ENABLE=0, go to IDLE, no DONE.
  - Else if term:
    - mode 0/1: go to IDLE, pulse DONE.
    - mode 2: pulse EVENT, go to LOAD.
    - mode 3: pulse EVENT, invert dir_r, set target_r to start_r if it was limit_r (else limit_r), stay in RUN.
  - Else CNT_ENABLE = TICK.
- CNT_ENABLE is 0 in every state except RUN with no term and no ABORT.
- Arithmetic is modulo 16, inherited from the counter. Step count to terminal = (START−LIMIT) mod 16 going down, (LIMIT−START) mod 16 going up. START>LIMIT in an up mode wraps through 15→0.
- START==LIMIT:
  - modes 0/1: DONE with zero ticks.
  - mode 2: EVENT every 2 cycles.
  - mode 3: EVENT every RUN cycle.
- STATUS_EVENTS increments with each EVENT and saturates at 2^EVW−1.
- ABORT outside RUN is ignored. CMD_VALID outside IDLE is not accepted (CMD_READY=0).

## Timing
- Reset (RST high at an edge) gives:
  - state=IDLE
  - DONE=EVENT=ERR=0, STATUS_EVENTS=0, dir_r=0, target_r=0
  - BUSY=0, CMD_READY=0 while RST is high, CMD_READY=1 the cycle after
- CNT_CLEAR=1 while RST is high.
- Reset mid-run abandons the run: no DONE, and the counter is cleared.
- Command accepted at edge c: LOAD during cycle c+1, Q=START and RUN from c+2.
- A TICK in RUN cycle k moves Q at edge k+1.
- term detected in cycle t: DONE/EVENT high in cycle t+1 only.
- One-shot with N steps and TICK held high: accept at c, DONE in cycle c+N+3. CMD_READY is high again in that same cycle.
- PERIODIC with TICK held high: EVENT period N+2 cycles.
- ERR is high in the cycle after the rejected handshake.

## Configuration
- PINGPONG_EN defined: mode 3 is supported as described.
- PINGPONG_EN undefined: the ping-pong logic is not compiled.
  - CMD_MODE=3 is accepted for one handshake, pulses ERR and stays in IDLE.
  - The counter is never loaded.

## Test plan
- Reset, then mode 0, START=5, LIMIT=2, TICK held high → CNT_LOAD in c+1; Q sequence 5,4,3,2; DONE single pulse in c+6; BUSY low in that cycle.
- Mode 1, START=14, LIMIT=1, TICK high on alternate cycles → Q wraps 14,15,0,1; exactly 3 enables; DONE once.
- Mode 2, START=3, LIMIT=0, TICK high, ABORT after the 4th EVENT → EVENT every 5 cycles; STATUS_EVENTS=4; CNT_CLEAR pulse; no DONE; back in IDLE.
- Mode 3 (PINGPONG_EN defined), START=1, LIMIT=3 → Q 1,2,3,2,1,2…; EVENT at each 3 and 1. Undefined: same command → ERR pulse, CNT_LOAD never asserted.
- START==LIMIT=7, mode 0 → DONE in c+3 with zero enables. CMD_VALID held high during BUSY → no second accept until the DONE cycle.
- RST asserted during RUN → next cycle IDLE, all pulses low, STATUS_EVENTS=0, CNT_CLEAR seen high.
